// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding and line-geometry helpers for the memory accessor port
package mem_pkg;
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_LOAD  = 3'd1;
   localparam state_t ST_MERGE = 3'd2;
   localparam state_t ST_STORE = 3'd3;
   localparam state_t ST_RESP  = 3'd4;
   localparam int DEF_BITSIZE = 32;
   localparam int DEF_N_WORDS = 4;
   function automatic int boff(input int bitsize);
      return $clog2(bitsize / 8);
   endfunction
   function automatic int wsel(input int n_words);
      return $clog2(n_words);
   endfunction
   function automatic int offs(input int bitsize, input int n_words);
      return boff(bitsize) + wsel(n_words);
   endfunction
   function automatic int idx_w(input int n_words);
      return (n_words > 1) ? $clog2(n_words) : 1;
   endfunction
   function automatic int line_w(input int bitsize, input int n_words);
      return bitsize * n_words;
   endfunction
   localparam int LINE_W = line_w(DEF_BITSIZE, DEF_N_WORDS);
endpackage

// File: rtl/mem_line_merge.sv
// mem_line_merge: replaces the bytes of one word of a line under byte enables
module mem_line_merge
   import mem_pkg::*;
#(
   parameter int BITSIZE = 32,
   parameter int N_WORDS_PER_ADDR = 4
) (
   input  logic [line_w(BITSIZE, N_WORDS_PER_ADDR)-1:0] line,
   input  logic [idx_w(N_WORDS_PER_ADDR)-1:0]           idx,
   input  logic [BITSIZE-1:0]                           wdata,
   input  logic [BITSIZE/8-1:0]                         be,
   output logic [line_w(BITSIZE, N_WORDS_PER_ADDR)-1:0] merged
);
   localparam int NB = BITSIZE / 8;
   // start from the old line and overwrite only enabled bytes of the selected word
   always_comb begin
      merged = line;
      for (int b = 0; b < NB; b++)
         merged[idx*BITSIZE + b*8 +: 8] = be[b] ? wdata[b*8 +: 8] : line[idx*BITSIZE + b*8 +: 8];
   end
endmodule

// File: rtl/mem_acc_port.sv
// mem_acc_port: turns single-word requests into line load / read-modify-write store transactions
module mem_acc_port
   import mem_pkg::*;
#(
   parameter int BITSIZE = 32,
   parameter int N_WORDS_PER_ADDR = 4
) (
   input  logic                                         clk,
   input  logic                                         resetn_i,
   input  logic                                         req_valid_i,
   output logic                                         req_ready_o,
   input  logic                                         req_we_i,
   input  logic [31:0]                                  req_addr_i,
   input  logic [BITSIZE-1:0]                           req_wdata_i,
   input  logic [BITSIZE/8-1:0]                         req_be_i,
   output logic                                         rsp_valid_o,
   output logic [BITSIZE-1:0]                           rsp_rdata_o,
   output logic [31:0]                                  acc_address_o,
   output logic                                         acc_load_o,
   output logic                                         acc_store_o,
   output logic [line_w(BITSIZE, N_WORDS_PER_ADDR)-1:0] acc_data_o,
   input  logic [line_w(BITSIZE, N_WORDS_PER_ADDR)-1:0] acc_data_i,
   input  logic                                         acc_done_i
);
   localparam int BOFF = boff(BITSIZE);
   localparam int WSEL = wsel(N_WORDS_PER_ADDR);
   localparam int OFFS = offs(BITSIZE, N_WORDS_PER_ADDR);
   localparam int LW   = line_w(BITSIZE, N_WORDS_PER_ADDR);
   localparam int WI   = idx_w(N_WORDS_PER_ADDR);
   state_t               state_q;
   logic                 we_q;
   logic [WI-1:0]        idx_q;
   logic [WI-1:0]        req_idx;
   logic [BITSIZE-1:0]   wdata_q;
   logic [BITSIZE/8-1:0] be_q;
   logic [LW-1:0]        line_q;
   logic [LW-1:0]        merged;
   assign req_idx     = (WSEL > 0) ? WI'(req_addr_i >> BOFF) : '0;
   assign req_ready_o = (state_q == ST_IDLE);
   mem_line_merge #(
      .BITSIZE(BITSIZE),
      .N_WORDS_PER_ADDR(N_WORDS_PER_ADDR)
   ) u_merge (
      .line(line_q),
      .idx(idx_q),
      .wdata(wdata_q),
      .be(be_q),
      .merged(merged)
   );
   // request FSM; controller and response outputs are registered so they change only on state transitions
   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q       <= ST_IDLE;
         we_q          <= 1'b0;
         idx_q         <= '0;
         wdata_q       <= '0;
         be_q          <= '0;
         line_q        <= '0;
         acc_load_o    <= 1'b0;
         acc_store_o   <= 1'b0;
         acc_address_o <= '0;
         acc_data_o    <= '0;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (req_valid_i) begin
               we_q          <= req_we_i;
               idx_q         <= req_idx;
               wdata_q       <= req_wdata_i;
               be_q          <= req_be_i;
               acc_address_o <= req_addr_i >> OFFS;
               acc_load_o    <= 1'b1;
               state_q       <= ST_LOAD;
            end
            ST_LOAD: if (acc_done_i) begin
               acc_load_o <= 1'b0;
               line_q     <= acc_data_i;
               if (we_q) state_q <= ST_MERGE;
               else begin
                  rsp_valid_o <= 1'b1;
                  rsp_rdata_o <= acc_data_i[idx_q*BITSIZE +: BITSIZE];
                  state_q     <= ST_RESP;
               end
            end
            ST_MERGE: begin
               line_q      <= merged;
               acc_data_o  <= merged;
               acc_store_o <= 1'b1;
               state_q     <= ST_STORE;
            end
            ST_STORE: if (acc_done_i) begin
               acc_store_o <= 1'b0;
               rsp_valid_o <= 1'b1;
               rsp_rdata_o <= line_q[idx_q*BITSIZE +: BITSIZE];
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               rsp_valid_o <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_acc_port.sv
// tb_mem_acc_port: table, random and corner-case checks of the accessor port against a line/byte model
module tb_mem_acc_port;
   localparam int BS = 32;
   localparam int NW = 4;
   localparam int LW = 128;
   localparam logic [127:0] L0 = 128'h44444444_33333333_22222222_11111111;
   typedef struct {
      logic         we;
      logic [31:0]  addr;
      logic [31:0]  wd;
      logic [3:0]   be;
      int           kl;
      int           ks;
      logic [31:0]  e_addr;
      logic [31:0]  e_rd;
      logic [127:0] e_line;
   } vec_t;
   logic          clk = 1'b0;
   logic          resetn_i = 1'b0;
   logic          req_valid_i = 1'b0;
   logic          req_we_i = 1'b0;
   logic [31:0]   req_addr_i = '0;
   logic [31:0]   req_wdata_i = '0;
   logic [3:0]    req_be_i = '0;
   logic          acc_done_i = 1'b0;
   logic [LW-1:0] acc_data_i = '0;
   logic          req_ready_o, rsp_valid_o, acc_load_o, acc_store_o;
   logic [31:0]   rsp_rdata_o, acc_address_o;
   logic [LW-1:0] acc_data_o;
   int            n_chk = 0;
   int            n_err = 0;
   vec_t          v[6];
   always #5 clk = ~clk;
   mem_acc_port #(.BITSIZE(BS), .N_WORDS_PER_ADDR(NW)) dut (
      .clk(clk), .resetn_i(resetn_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
      .acc_address_o(acc_address_o), .acc_load_o(acc_load_o), .acc_store_o(acc_store_o),
      .acc_data_o(acc_data_o), .acc_data_i(acc_data_i), .acc_done_i(acc_done_i)
   );
   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask
   // line as 16 bytes; the addressed word is (addr mod 16)/4, stores replace enabled bytes of it
   function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [3:0] be, input logic [127:0] line,
                                 output logic [31:0] rd, output logic [127:0] nl);
      logic [7:0] b[16];
      int w;
      w = int'((addr % 32'd16) / 32'd4);
      for (int i = 0; i < 16; i++) b[i] = line[8*i +: 8];
      if (we) for (int j = 0; j < 4; j++) if (be[j]) b[4*w + j] = wd[8*j +: 8];
      for (int i = 0; i < 16; i++) nl[8*i +: 8] = b[i];
      rd = nl[32*w +: 32];
   endfunction
   // issue one request, act as the controller, and compare everything observed
   task automatic run_txn(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [127:0] line, input int kl, input int ks,
                          input int pulse_at, input logic [31:0] e_addr, input logic [31:0] e_rd,
                          input logic [127:0] e_line);
      int cl, cs, n_load, n_store, n_rsp, tail, rc;
      logic stable;
      logic [31:0] a0, rd;
      logic [127:0] d0, st;
      for (int i = 0; i < 20 && !req_ready_o; i++) @(negedge clk);
      chk({tag, "_ready"}, req_ready_o, 1'b1);
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd; req_be_i = be;
      @(negedge clk);
      req_valid_i = 1'b0;
      cl = 0; cs = 0; n_load = 0; n_store = 0; n_rsp = 0; tail = 0; rc = -1;
      stable = 1'b1; a0 = acc_address_o; d0 = acc_data_o; st = '0; rd = '0;
      for (int c = 0; c < 300 && tail < 4; c++) begin
         if (acc_load_o && acc_store_o) stable = 1'b0;
         if (acc_address_o !== a0) stable = 1'b0;
         if (acc_load_o) begin
            if (acc_data_o !== d0) stable = 1'b0;
            n_load++;
            acc_done_i = (cl == kl);
            acc_data_i = acc_done_i ? line : {$urandom, $urandom, $urandom, $urandom};
            cl++;
         end else if (acc_store_o) begin
            if (n_store == 0) st = acc_data_o;
            else if (acc_data_o !== st) stable = 1'b0;
            n_store++;
            acc_done_i = (cs == ks);
            cs++;
         end else begin
            acc_done_i = 1'($urandom_range(0, 1));
            acc_data_i = {$urandom, $urandom, $urandom, $urandom};
         end
         if (c == pulse_at) begin
            req_valid_i = 1'b1; req_addr_i = ~addr; req_we_i = ~we;
         end else req_valid_i = 1'b0;
         if (rsp_valid_o) begin
            if (n_rsp == 0) begin rd = rsp_rdata_o; rc = c; end
            n_rsp++;
         end
         if (n_rsp > 0) tail++;
         @(negedge clk);
      end
      acc_done_i = 1'b0;
      req_valid_i = 1'b0;
      chk({tag, "_addr"}, a0, e_addr);
      chk({tag, "_rdata"}, rd, e_rd);
      chk({tag, "_nload"}, 128'(n_load), 128'(kl + 1));
      chk({tag, "_nstore"}, 128'(n_store), we ? 128'(ks + 1) : 128'(0));
      if (we) chk({tag, "_line"}, st, e_line);
      chk({tag, "_nrsp"}, 128'(n_rsp), 128'(1));
      chk({tag, "_lat"}, 128'(rc), we ? 128'(kl + ks + 3) : 128'(kl + 1));
      chk({tag, "_stable"}, stable, 1'b1);
   endtask
   initial begin
      int n;
      logic we;
      logic [31:0] a, wd, rd;
      logic [3:0] be;
      logic [127:0] ln, nl;
      int kl, ks;
      #12;
      chk("rst_load", acc_load_o, 1'b0);
      chk("rst_store", acc_store_o, 1'b0);
      chk("rst_addr", acc_address_o, 32'h0);
      chk("rst_data", acc_data_o, 128'h0);
      chk("rst_rsp", {rsp_valid_o, rsp_rdata_o}, 33'h0);
      @(negedge clk); resetn_i = 1'b1;
      @(negedge clk);
      chk("rst_ready", req_ready_o, 1'b1);
      chk("rst_idle_out", {acc_load_o, acc_store_o, rsp_valid_o}, 3'b000);
      v[0] = '{we:1'b0, addr:32'h108, wd:32'h0, be:4'h0, kl:2, ks:0,
               e_addr:32'h10, e_rd:32'h33333333, e_line:128'h0};
      v[1] = '{we:1'b1, addr:32'h104, wd:32'hDEADBEEF, be:4'hF, kl:1, ks:2,
               e_addr:32'h10, e_rd:32'hDEADBEEF, e_line:128'h44444444_33333333_DEADBEEF_11111111};
      v[2] = '{we:1'b1, addr:32'h100, wd:32'hAAAA5555, be:4'h3, kl:0, ks:0,
               e_addr:32'h10, e_rd:32'h11115555, e_line:128'h44444444_33333333_22222222_11115555};
      v[3] = '{we:1'b1, addr:32'h20C, wd:32'h12345678, be:4'h0, kl:3, ks:1,
               e_addr:32'h20, e_rd:32'h44444444, e_line:L0};
      v[4] = '{we:1'b0, addr:32'hFFFFFFFF, wd:32'h0, be:4'h0, kl:0, ks:0,
               e_addr:32'h0FFFFFFF, e_rd:32'h44444444, e_line:128'h0};
      v[5] = '{we:1'b1, addr:32'h3E, wd:32'hCAFEF00D, be:4'hC, kl:2, ks:4,
               e_addr:32'h3, e_rd:32'hCAFE4444, e_line:128'hCAFE4444_33333333_22222222_11111111};
      for (int i = 0; i < 6; i++)
         run_txn($sformatf("vec%0d", i), v[i].we, v[i].addr, v[i].wd, v[i].be, L0,
                 v[i].kl, v[i].ks, -1, v[i].e_addr, v[i].e_rd, v[i].e_line);
      run_txn("hold", 1'b0, 32'h108, 32'h0, 4'h0, L0, 10, 0, 4, 32'h10, 32'h33333333, 128'h0);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         if (acc_load_o || acc_store_o || rsp_valid_o) n++;
         @(negedge clk);
      end
      chk("hold_no_second", 128'(n), 128'(0));
      for (int i = 0; i < 40; i++) begin
         we = 1'($urandom_range(0, 1));
         a = $urandom; wd = $urandom; be = 4'($urandom);
         ln = {$urandom, $urandom, $urandom, $urandom};
         kl = $urandom_range(0, 4); ks = $urandom_range(0, 4);
         model(we, a, wd, be, ln, rd, nl);
         run_txn($sformatf("rnd%0d", i), we, a, wd, be, ln, kl, ks,
                 $urandom_range(0, we ? kl + ks + 3 : kl + 1), a >> 4, rd, nl);
      end
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h104; req_wdata_i = 32'h1; req_be_i = 4'hF;
      @(negedge clk);
      req_valid_i = 1'b0;
      for (int c = 0; c < 20 && !acc_store_o; c++) begin
         acc_done_i = acc_load_o;
         acc_data_i = L0;
         @(negedge clk);
      end
      acc_done_i = 1'b0;
      chk("rstmid_store_hi", acc_store_o, 1'b1);
      #1 resetn_i = 1'b0;
      #1;
      chk("rstmid_store_lo", acc_store_o, 1'b0);
      chk("rstmid_outs", {acc_load_o, rsp_valid_o, acc_address_o}, 34'h0);
      chk("rstmid_data", acc_data_o, 128'h0);
      @(negedge clk); resetn_i = 1'b1;
      @(negedge clk);
      chk("rstmid_ready", req_ready_o, 1'b1);
      n = 0;
      acc_done_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid_o || acc_load_o || acc_store_o) n++;
      end
      acc_done_i = 1'b0;
      chk("rstmid_stray_done", 128'(n), 128'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
